// File: rtl/mmio_pkg.sv
// Shared types and constants for the mmio_bus interconnect: FSM states,
// region map of the standard SoC peripherals and error-counter helpers.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] REGION_ROM  = 4'd0;
    localparam logic [3:0] REGION_RAM  = 4'd1;
    localparam logic [3:0] REGION_VGA  = 4'd2;
    localparam logic [3:0] REGION_UART = 4'd3;

    localparam int ERR_COUNT_W = 8;

    // Saturating increment so the error counter sticks at all-ones.
    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] value);
        logic [ERR_COUNT_W-1:0] result;
        if (value == {ERR_COUNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(ERR_COUNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// Address decoder: splits a master address into slave region, in-region
// offset and a hit flag telling whether the region maps to a real slave.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int NSLAVES     = 4,
    parameter int ADDR_W      = 32,
    parameter int REGION_BITS = 4
) (
    input  logic [ADDR_W-1:0]             addr,
    output logic [REGION_BITS-1:0]        sel,
    output logic [ADDR_W-REGION_BITS-1:0] offset,
    output logic                          hit
);

    // Slave count clamped to the number of encodable regions so the limit fits.
    localparam int NS_CAP = (NSLAVES > (2 ** REGION_BITS)) ? (2 ** REGION_BITS) : NSLAVES;
    localparam logic [REGION_BITS:0] NS_LIM = (REGION_BITS + 1)'(NS_CAP);

    // Pure combinational split of the address.
    always_comb begin
        sel    = addr[ADDR_W-1 -: REGION_BITS];
        offset = addr[ADDR_W-REGION_BITS-1:0];
        hit    = ({1'b0, sel} < NS_LIM);
    end

endmodule

// File: rtl/mmio_bus.sv
// Single-outstanding memory-mapped interconnect from the core data port to
// NSLAVES peripherals with decode-error, slave-timeout and error counting.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int NSLAVES     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int REGION_BITS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          m_valid,
    input  logic                          m_write,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic [DATA_W-1:0]             m_wdata,
    output logic                          m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_err,
    output logic [NSLAVES-1:0]            s_valid,
    output logic                          s_write,
    output logic [ADDR_W-REGION_BITS-1:0] s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [NSLAVES-1:0]            s_ready,
    input  logic [NSLAVES*DATA_W-1:0]     s_rdata,
    output logic [ERR_COUNT_W-1:0]        err_count
);

    localparam int OFF_W = ADDR_W - REGION_BITS;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t state_r;
    state_t state_nxt_s;

    logic [REGION_BITS-1:0] dec_sel_s;
    logic [OFF_W-1:0]       dec_off_s;
    logic                   dec_hit_s;

    logic [NSLAVES-1:0]     onehot_s;
    logic                   rdy_sel_s;
    logic [DATA_W-1:0]      rdata_sel_s;

    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic [REGION_BITS-1:0] sel_r, sel_nxt_s;
    logic                   ready_r, ready_nxt_s;
    logic [DATA_W-1:0]      rdata_r, rdata_nxt_s;
    logic                   err_r, err_nxt_s;
    logic [NSLAVES-1:0]     s_valid_r, s_valid_nxt_s;
    logic                   write_r, write_nxt_s;
    logic [OFF_W-1:0]       addr_r, addr_nxt_s;
    logic [DATA_W-1:0]      wdata_r, wdata_nxt_s;
    logic [ERR_COUNT_W-1:0] err_count_r, err_count_nxt_s;

    mmio_decode #(
        .NSLAVES     (NSLAVES),
        .ADDR_W      (ADDR_W),
        .REGION_BITS (REGION_BITS)
    ) u_decode (
        .addr   (m_addr),
        .sel    (dec_sel_s),
        .offset (dec_off_s),
        .hit    (dec_hit_s)
    );

    // Strobe pattern for a new request, and ready/data of the latched slave.
    always_comb begin
        onehot_s    = {NSLAVES{1'b0}};
        rdy_sel_s   = 1'b0;
        rdata_sel_s = {DATA_W{1'b0}};
        for (int i = 0; i < NSLAVES; i++) begin
            onehot_s[i] = (dec_sel_s == REGION_BITS'(i));
            rdy_sel_s   = rdy_sel_s | (s_ready[i] & (sel_r == REGION_BITS'(i)));
            rdata_sel_s = rdata_sel_s
                        | ({DATA_W{sel_r == REGION_BITS'(i)}} & s_rdata[i*DATA_W +: DATA_W]);
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        sel_nxt_s       = sel_r;
        ready_nxt_s     = 1'b0;
        rdata_nxt_s     = rdata_r;
        err_nxt_s       = err_r;
        s_valid_nxt_s   = s_valid_r;
        write_nxt_s     = write_r;
        addr_nxt_s      = addr_r;
        wdata_nxt_s     = wdata_r;
        err_count_nxt_s = err_count_r;

        case (state_r)
            ST_IDLE: begin
                if (m_valid) begin
                    write_nxt_s = m_write;
                    addr_nxt_s  = dec_off_s;
                    wdata_nxt_s = m_wdata;
                    sel_nxt_s   = dec_sel_s;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    if (dec_hit_s) begin
                        s_valid_nxt_s = onehot_s;
                        state_nxt_s   = ST_REQ;
                    end else begin
                        ready_nxt_s     = 1'b1;
                        err_nxt_s       = 1'b1;
                        rdata_nxt_s     = {DATA_W{1'b0}};
                        err_count_nxt_s = sat_inc(err_count_r);
                        state_nxt_s     = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A slave answering on the last allowed cycle still counts as success.
                if (rdy_sel_s) begin
                    rdata_nxt_s   = write_r ? {DATA_W{1'b0}} : rdata_sel_s;
                    err_nxt_s     = 1'b0;
                    ready_nxt_s   = 1'b1;
                    s_valid_nxt_s = {NSLAVES{1'b0}};
                    state_nxt_s   = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    rdata_nxt_s     = {DATA_W{1'b0}};
                    err_nxt_s       = 1'b1;
                    ready_nxt_s     = 1'b1;
                    s_valid_nxt_s   = {NSLAVES{1'b0}};
                    err_count_nxt_s = sat_inc(err_count_r);
                    state_nxt_s     = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                s_valid_nxt_s = {NSLAVES{1'b0}};
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            sel_r       <= {REGION_BITS{1'b0}};
            ready_r     <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
            err_r       <= 1'b0;
            s_valid_r   <= {NSLAVES{1'b0}};
            write_r     <= 1'b0;
            addr_r      <= {OFF_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            err_count_r <= {ERR_COUNT_W{1'b0}};
        end else begin
            cnt_r       <= cnt_nxt_s;
            sel_r       <= sel_nxt_s;
            ready_r     <= ready_nxt_s;
            rdata_r     <= rdata_nxt_s;
            err_r       <= err_nxt_s;
            s_valid_r   <= s_valid_nxt_s;
            write_r     <= write_nxt_s;
            addr_r      <= addr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            err_count_r <= err_count_nxt_s;
        end
    end

    assign m_ready   = ready_r;
    assign m_rdata   = rdata_r;
    assign m_err     = err_r;
    assign s_valid   = s_valid_r;
    assign s_write   = write_r;
    assign s_addr    = addr_r;
    assign s_wdata   = wdata_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_mmio_bus.sv
// Self-checking bench for mmio_bus: table of single transactions with a
// response scoreboard, plus reset, back-to-back and saturation sequences.
module tb_mmio_bus;
    import mmio_pkg::*;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RB = 4;
    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               m_valid;
    logic               m_write;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic               m_ready;
    logic [DW-1:0]      m_rdata;
    logic               m_err;
    logic [NS-1:0]      s_valid;
    logic               s_write;
    logic [AW-RB-1:0]   s_addr;
    logic [DW-1:0]      s_wdata;
    logic [NS-1:0]      s_ready;
    logic [NS*DW-1:0]   s_rdata;
    logic [7:0]         err_count;

    mmio_bus #(
        .NSLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .REGION_BITS(RB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
        .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_cyc;
        logic        noise;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [7:0] err_model = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m_ready"}, 64'(m_ready), 64'd0);
        check({tag, "_m_rdata"}, 64'(m_rdata), 64'd0);
        check({tag, "_m_err"}, 64'(m_err), 64'd0);
        check({tag, "_s_valid"}, 64'(s_valid), 64'd0);
        check({tag, "_s_write"}, 64'(s_write), 64'd0);
        check({tag, "_s_addr"}, 64'(s_addr), 64'd0);
        check({tag, "_s_wdata"}, 64'(s_wdata), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        exp_t          e;
        int            sel;
        int            cyc;
        int            sv_cnt;
        logic          bad_bits;
        logic          got;
        logic [NS-1:0] exp_oh;
        sel    = int'(v.addr[31:28]);
        exp_oh = '0;
        if (sel < NS) exp_oh[sel] = 1'b1;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        sb_q.push_back(e);
        if (v.exp_err) err_model = (err_model == 8'hFF) ? 8'hFF : err_model + 8'd1;

        @(negedge clk);
        m_valid = 1'b1;
        m_write = v.write;
        m_addr  = v.addr;
        m_wdata = v.wdata;
        for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = (i == sel) ? v.rdata : ~v.rdata;
        s_ready = v.noise ? ~exp_oh : '0;
        sv_cnt = 0; bad_bits = 1'b0; got = 1'b0; cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (s_valid != '0) begin
                sv_cnt++;
                if (s_valid != exp_oh) bad_bits = 1'b1;
            end
            if (cyc == 1 && exp_oh != '0) begin
                check("s_addr", 64'(s_addr), 64'(v.addr[27:0]));
                check("s_write", 64'(s_write), 64'(v.write));
                check("s_wdata", 64'(s_wdata), 64'(v.wdata));
            end
            if (m_ready) begin
                got = 1'b1;
                m_valid = 1'b0;
                s_ready = '0;
                if (sb_q.size() == 0) begin
                    check("sb_empty", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("m_rdata", 64'(m_rdata), 64'(e.rdata));
                    check("m_err", 64'(m_err), 64'(e.err));
                    check("latency", 64'(cyc), 64'(e.lat));
                    check("err_count", 64'(err_count), 64'(err_model));
                end
            end else begin
                s_ready = v.noise ? ~exp_oh : '0;
                if (v.wait_cyc >= 0 && cyc == v.wait_cyc + 1) s_ready = s_ready | exp_oh;
            end
        end
        if (!got) begin
            check("txn_no_ready", 64'(got), 64'd1);
            m_valid = 1'b0;
            s_ready = '0;
            if (sb_q.size() != 0) e = sb_q.pop_front();
        end
        check("s_valid_cycles", 64'(sv_cnt), 64'((exp_oh != '0) ? (v.exp_lat - 1) : 0));
        check("s_valid_onehot", 64'(bad_bits), 64'd0);
        @(negedge clk);
        check("m_ready_pulse", 64'(m_ready), 64'd0);
    endtask

    vec_t vecs[8];
    vec_t tov;
    vec_t fresh;
    exp_t e2;
    logic [7:0] mr_hist;
    logic [7:0] sv0_hist;
    logic       sv_other;
    logic       mr_seen;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, {REGION_RAM, 28'h000_0040}, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 2};
        vecs[1] = '{1'b1, {REGION_VGA, 28'h000_0004}, 32'h1234_5678, 32'hDEAD_BEEF, 3, 1'b0, 32'h0, 1'b0, 5};
        vecs[2] = '{1'b0, 32'h9000_0000, 32'h0, 32'h1357_9BDF, 0, 1'b0, 32'h0, 1'b1, 1};
        vecs[3] = '{1'b0, {REGION_ROM, 28'h000_0010}, 32'h0, 32'h0BAD_C0DE, 7, 1'b0, 32'h0BAD_C0DE, 1'b0, 9};
        vecs[4] = '{1'b0, {REGION_UART, 28'hFFF_FFFC}, 32'h0, 32'h2468_ACE0, -1, 1'b1, 32'h0, 1'b1, 9};
        vecs[5] = '{1'b1, {REGION_RAM, 28'hABC_DEF0}, 32'hFEED_0005, 32'h8888_9999, 1, 1'b1, 32'h0, 1'b0, 3};
        vecs[6] = '{1'b0, 32'hF000_0000, 32'h0, 32'h4444_4444, 0, 1'b1, 32'h0, 1'b1, 1};
        vecs[7] = '{1'b0, {REGION_UART, 28'h000_0008}, 32'h0, 32'h5A5A_A5A5, 6, 1'b1, 32'h5A5A_A5A5, 1'b0, 8};
        tov     = '{1'b0, {REGION_UART, 28'h000_0000}, 32'h0, 32'h7777_7777, -1, 1'b0, 32'h0, 1'b1, 9};
        fresh   = '{1'b0, {REGION_RAM, 28'h000_0200}, 32'h0, 32'h1111_2222, 2, 1'b0, 32'h1111_2222, 1'b0, 4};

        reset = 1'b1; m_valid = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
        s_ready = '0; s_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reset lands on the edge ending cycle 2 of a pending write.
        @(negedge clk);
        m_valid = 1'b1; m_write = 1'b1; m_addr = {REGION_VGA, 28'h000_0100}; m_wdata = 32'hA5A5_0001;
        s_ready = '0;
        @(negedge clk);
        check("rst_pre_s_valid", 64'(s_valid), 64'h4);
        @(negedge clk);
        reset = 1'b1; m_valid = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        reset = 1'b0;
        mr_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mr_seen = mr_seen | m_ready;
        end
        check("rst_no_ready", 64'(mr_seen), 64'd0);
        err_model = 8'd0;
        run_txn(fresh);

        // Two back-to-back zero-wait ROM reads with m_valid held throughout.
        @(negedge clk);
        m_valid = 1'b1; m_write = 1'b0; m_addr = {REGION_ROM, 28'h000_0100};
        s_rdata = '0;
        s_rdata[DW-1:0] = 32'h1111_0001;
        s_ready = 4'b0001;
        e2.err = 1'b0; e2.lat = 0;
        e2.rdata = 32'h1111_0001; sb_q.push_back(e2);
        e2.rdata = 32'h2222_0002; sb_q.push_back(e2);
        mr_hist = '0; sv0_hist = '0; sv_other = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            mr_hist[c]  = m_ready;
            sv0_hist[c] = s_valid[0];
            sv_other    = sv_other | (|s_valid[3:1]);
            if (m_ready) begin
                if (sb_q.size() == 0) begin
                    check("b2b_sb_empty", 64'(sb_q.size()), 64'd1);
                end else begin
                    e2 = sb_q.pop_front();
                    check("b2b_rdata", 64'(m_rdata), 64'(e2.rdata));
                    check("b2b_err", 64'(m_err), 64'(e2.err));
                end
            end
            if (c == 2) s_rdata[DW-1:0] = 32'h2222_0002;
            if (c == 5) m_valid = 1'b0;
        end
        s_ready = '0;
        check("b2b_ready_cycles", 64'(mr_hist), 64'h24);
        check("b2b_s_valid_cycles", 64'(sv0_hist), 64'h12);
        check("b2b_other_s_valid", 64'(sv_other), 64'd0);
        check("b2b_sb_drained", 64'(sb_q.size()), 64'd0);
        while (sb_q.size() != 0) e2 = sb_q.pop_front();

        // Repeated timeouts drive the error counter into saturation.
        for (int n = 0; n < 300; n++) run_txn(tov);
        @(negedge clk);
        check("err_count_saturated", 64'(err_count), 64'd255);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
